// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: operation codes,
// widths and FSM state values.
package muldiv_seq_pkg;

    localparam int MD_OP_WIDTH = 2;
    localparam int CNT_WIDTH   = 5;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULT  = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULTU = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV   = 2'd2;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_FIX  = 2'd2
    } md_state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] md_mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider.
// acc_in = {upper, lower}: multiply {partial, multiplier}, divide {rem, quotient}.
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [31:0] diff;
    logic        no_borrow;

    always_comb begin
        sum       = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
        rem_sh    = {acc_in[63:32], acc_in[31]};
        // The remainder stays below the divisor, so the difference fits in 32 bits.
        no_borrow = (rem_sh >= {1'b0, operand});
        diff      = rem_sh[31:0] - operand;
        if (is_div) begin
            if (no_borrow) begin
                acc_out = {diff, acc_in[30:0], 1'b1};
            end else begin
                acc_out = {rem_sh[31:0], acc_in[30:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per cycle,
// 32 CALC cycles plus one FIX cycle for sign correction and write-back.
module muldiv_seq #(
    parameter int MD_OP_WIDTH = muldiv_seq_pkg::MD_OP_WIDTH,
    parameter int CNT_WIDTH   = muldiv_seq_pkg::CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [MD_OP_WIDTH-1:0] md_op,
    input  logic [31:0]            op1,
    input  logic [31:0]            op2,
    input  logic                   mthi,
    input  logic                   mtlo,
    input  logic                   hilo_access,
    input  logic                   cancel,
    output logic [31:0]            hi,
    output logic [31:0]            lo,
    output logic                   busy,
    output logic                   stall,
    output logic                   done
);

    import muldiv_seq_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;

    md_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [63:0]           acc_q, acc_d;
    logic [31:0]           opb_q, opb_d;
    logic                  sa_q, sa_d;
    logic                  sb_q, sb_d;
    logic                  div_q, div_d;
    logic [31:0]           hi_q, hi_d;
    logic [31:0]           lo_q, lo_d;
    logic                  done_q, done_d;

    logic                  start_div;
    logic                  start_signed;
    logic [63:0]           step_out;
    logic [63:0]           prod_neg;
    logic [31:0]           quo_neg;
    logic [31:0]           rem_neg;

    muldiv_step u_step (
        .is_div  (div_q),
        .acc_in  (acc_q),
        .operand (opb_q),
        .acc_out (step_out)
    );

    assign start_div    = (md_op == MD_OP_DIV) || (md_op == MD_OP_DIVU);
    assign start_signed = (md_op == MD_OP_MULT) || (md_op == MD_OP_DIV);
    assign prod_neg     = ~acc_q + 64'd1;
    assign quo_neg      = ~acc_q[31:0] + 32'd1;
    assign rem_neg      = ~acc_q[63:32] + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_ST_IDLE: if (start && !cancel) state_d = MD_ST_CALC;
            MD_ST_CALC: begin
                if (cancel) begin
                    state_d = MD_ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = MD_ST_FIX;
                end
            end
            MD_ST_FIX:  state_d = MD_ST_IDLE;
            default:    state_d = MD_ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opb_d  = opb_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        div_d  = div_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        case (state_q)
            MD_ST_IDLE: begin
                // A flush in IDLE swallows start/mthi/mtlo of the same cycle.
                if (!cancel) begin
                    if (start) begin
                        sa_d  = start_signed & op1[31];
                        sb_d  = start_signed & op2[31];
                        div_d = start_div;
                        opb_d = start_div ? md_mag32(op2, start_signed) : md_mag32(op1, start_signed);
                        acc_d = {32'd0, start_div ? md_mag32(op1, start_signed) : md_mag32(op2, start_signed)};
                        cnt_d = '0;
                    end else begin
                        if (mthi) hi_d = op1;
                        if (mtlo) lo_d = op1;
                    end
                end
            end
            MD_ST_CALC: begin
                if (cancel) begin
                    cnt_d = '0;
                end else begin
                    acc_d = step_out;
                    if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                end
            end
            MD_ST_FIX: begin
                cnt_d = '0;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        lo_d = (sa_q ^ sb_q) ? quo_neg : acc_q[31:0];
                        hi_d = sa_q ? rem_neg : acc_q[63:32];
                    end else begin
                        {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign busy  = (state_q != MD_ST_IDLE);
    assign stall = busy & hilo_access;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector bench for muldiv_seq: table of operations plus hand-written
// stall, cancel and asynchronous-reset sequences.
module tb_muldiv_seq;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;
    localparam int         LAT      = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        hilo_access = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    int tests = 0;
    int fails = 0;

    muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .md_op       (md_op),
        .op1         (op1),
        .op2         (op2),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .hilo_access (hilo_access),
        .cancel      (cancel),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .stall       (stall),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, got);
        end
    endtask

    // Called #1 after an edge; watches up to max_cyc edges for done.
    task automatic wait_done(input int max_cyc, output int lat, output int nd, output logic busy_at_done);
        lat = -1;
        nd = 0;
        busy_at_done = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (lat < 0) begin
                    lat = c;
                    busy_at_done = busy;
                end
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_op = op; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int lat, nd;
        logic bad;
        logic [31:0] save_hi, save_lo;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
        vecs[6]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        // Reset state
        hilo_access = 1'b1;
        #1;
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_busy_done_stall", {61'd0, busy, done, stall}, 64'd0);
        hilo_access = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven operations
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy_after_start", i), {63'd0, busy}, 64'd1);
            wait_done(60, lat, nd, bad);
            chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("v%0d_done_count", i), 64'(nd), 64'd1);
            chk($sformatf("v%0d_busy_at_done", i), {63'd0, bad}, 64'd0);
        end

        // Stall: mtlo and a second start during a busy MULTU are ignored
        save_lo = lo;
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        lat = -1;
        nd = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin
                @(negedge clk);
                hilo_access = 1'b1; mtlo = 1'b1; op1 = 32'h12345678;
                #1;
                chk("stall_during_busy", {63'd0, stall}, 64'd1);
            end
            if (c == 10) begin
                @(negedge clk);
                start = 1'b1; md_op = OP_MULT; op1 = 32'h00000003; op2 = 32'h00000003;
            end
            @(posedge clk); #1;
            if (c == 5) begin
                mtlo = 1'b0; hilo_access = 1'b0;
                chk("mtlo_ignored_when_busy", {32'd0, lo}, {32'd0, save_lo});
            end
            if (c == 10) start = 1'b0;
            if (done) begin
                nd++;
                if (lat < 0) lat = c;
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
        chk("stall_seq_hi", {32'd0, hi}, 64'h00000000_FFFFFFFE);
        chk("stall_seq_lo", {32'd0, lo}, 64'h00000000_00000001);
        chk("stall_seq_latency", 64'(lat), 64'(LAT));
        chk("stall_seq_done_count", 64'(nd), 64'd1);
        hilo_access = 1'b1;
        #1;
        chk("no_stall_when_idle", {63'd0, stall}, 64'd0);
        hilo_access = 1'b0;

        // mthi+mtlo together, then mtlo alone
        @(negedge clk);
        op1 = 32'hAAAAAAAA; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo_both", {hi, lo}, 64'hAAAAAAAA_AAAAAAAA);
        @(negedge clk);
        op1 = 32'h55555555; mtlo = 1'b1;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mtlo_only", {hi, lo}, 64'hAAAAAAAA_55555555);

        // Cancel at cycle 10 of a DIVU
        start_op(OP_DIVU, 32'h00000064, 32'h00000007);
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy_low", {63'd0, busy}, 64'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("cancel_no_done", 64'(nd), 64'd0);
        chk("cancel_hilo_kept", {hi, lo}, 64'hAAAAAAAA_55555555);

        // Cancel in IDLE suppresses start and mtlo
        @(negedge clk);
        cancel = 1'b1; start = 1'b1; mtlo = 1'b1; md_op = OP_MULTU; op1 = 32'h00000002; op2 = 32'h00000003;
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0; mtlo = 1'b0;
        chk("idle_cancel_no_start", {63'd0, busy}, 64'd0);
        chk("idle_cancel_no_mtlo", {hi, lo}, 64'hAAAAAAAA_55555555);

        // start wins over mtlo in the same cycle
        @(negedge clk);
        start = 1'b1; mtlo = 1'b1; md_op = OP_MULTU; op1 = 32'h00000002; op2 = 32'h00000003;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        chk("start_beats_mtlo", {32'd0, lo}, 64'h00000000_55555555);
        wait_done(60, lat, nd, bad);
        chk("start_mtlo_result", {hi, lo}, 64'h00000000_00000006);

        // Asynchronous reset at cycle 20 of a MULT
        start_op(OP_MULT, 32'h00000007, 32'h00000006);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        chk("async_reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(OP_MULT, 32'h00000007, 32'h00000006);
        wait_done(60, lat, nd, bad);
        chk("post_reset_result", {hi, lo}, 64'h00000000_0000002A);
        chk("post_reset_latency", 64'(lat), 64'(LAT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
